cmp_phase_shifter: RTL
======================

CMP_PHASE_SHIFTER -- requirements
Module: cmp_phase_shifter

Interface
REQ-001 Parameter STEPS_PER_CODE, default 35, MMCM fine-shift steps per CMP_CLK_PHASE code.
REQ-002 Parameter RST_CYCLES, default 8, MMCM reset pulse width in CLK cycles.
REQ-003 Parameter PSDONE_TMO, default 63, max cycles waiting for PSDONE.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 CLK  in  1  system clock; all logic on rising edge.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 CMP_PHS_CHANGE  in  1  request to move to CMP_CLK_PHASE; rising edge acts.
REQ-008 CMP_CLK_PHASE  in  5  target phase code, 0..31.
REQ-009 CMP_PHS_JTAG_RST  in  1  request MMCM reset and phase return to zero; rising edge acts.
REQ-010 MMCM_LOCK  in  1  comparator-clock MMCM locked.
REQ-011 PSDONE  in  1  MMCM phase-shift done, one-cycle pulse.
REQ-012 PSEN  out  1  MMCM phase-shift enable, one-cycle pulse per step.
REQ-013 PSINCDEC  out  1  step direction: 1 increment, 0 decrement.
REQ-014 CMP_PHS_RST  out  1  MMCM reset.
REQ-015 CMP_PHASE  out  11  current accumulated phase in fine steps.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 STATE  out  3  encoded state, for test points.
REQ-018 PS_ERR  out  1  sticky PSDONE-timeout flag.

Function
REQ-019 States, encoding: IDLE=0, LOAD=1, STEP=2, WAIT=3, MRST=4, LOCKW=5, DONE=6.
REQ-020 Both request inputs edge-detected with a one-cycle registered delay; each edge sets a pending flag.
REQ-021 Pending flags are held in every state and cleared only when serviced from IDLE.
REQ-022 IDLE: pending JTAG-reset -> MRST; otherwise pending change -> LOAD; JTAG reset wins when both are pending.
REQ-023 LOAD: latch target = CMP_CLK_PHASE x STEPS_PER_CODE in 11 bits (max 1085); target equal to CMP_PHASE -> DONE, else -> STEP.
REQ-024 STEP: PSEN high for exactly this one cycle; PSINCDEC = (target > CMP_PHASE), held stable until WAIT exits; -> WAIT.
REQ-025 WAIT: on PSDONE, CMP_PHASE +/-1 per PSINCDEC; then equal to target -> DONE, else -> STEP.
REQ-026 WAIT: PSDONE absent for PSDONE_TMO cycles -> set PS_ERR, leave CMP_PHASE unchanged, -> IDLE.
REQ-027 CMP_PHASE never wraps; it stays within 0..1085.
REQ-028 MRST: CMP_PHS_RST high for RST_CYCLES cycles, then -> LOCKW.
REQ-029 LOCKW: wait for MMCM_LOCK high; on lock CMP_PHASE=0 and PS_ERR cleared, -> DONE; no timeout.
REQ-030 DONE: one cycle, -> IDLE.
REQ-031 PSDONE outside WAIT is ignored.

Reset
REQ-032 RST forces, mid-operation included: IDLE, PSEN=0, PSINCDEC=0, CMP_PHS_RST=0, CMP_PHASE=0, BUSY=0, STATE=0, PS_ERR=0.
REQ-033 RST also clears pending flags and edge-detect registers and latches the target as 0.
REQ-034 The first rising edges after RST release are detected normally.

Structure
REQ-035 State encoding constants and the 11-bit phase width belong in the shared dcfeb package.
REQ-036 One sub-module, req_edge_latch (edge detect plus pending flag), instanced twice.
REQ-037 STATE and the psen/psdone/busy/rst signals are wired to the test-point block.

Verification
REQ-038 CMP_CLK_PHASE=3, CHANGE pulse, PSDONE 4 cycles after each PSEN -> 105 PSEN pulses, PSINCDEC=1, final CMP_PHASE=105, BUSY low after DONE.
REQ-039 From 105, code 1 -> 70 pulses, PSINCDEC=0, CMP_PHASE=35; from 35, code 1 -> LOAD->DONE, no PSEN.
REQ-040 PSDONE withheld -> PS_ERR=1 after 63 WAIT cycles, state IDLE, CMP_PHASE unchanged.
REQ-041 CHANGE and JTAG_RST in the same cycle -> MRST first (CMP_PHS_RST 8 cycles, lock, CMP_PHASE=0), then the change is serviced.
REQ-042 RST asserted during WAIT at CMP_PHASE=50 -> all outputs to reset values immediately; a later CHANGE starts from 0.

Source files
------------

// File: rtl/cmp_phase_shifter_pkg.sv
// Shared definitions for the comparator-clock phase shifter: state
// encoding, phase/code widths and the code-to-fine-step conversion.
package cmp_phase_shifter_pkg;

  localparam int unsigned PHASE_W = 11;
  localparam int unsigned CODE_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STEP  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_MRST  = 3'd4,
    ST_LOCKW = 3'd5,
    ST_DONE  = 3'd6
  } phs_state_t;

  // Phase code scaled to MMCM fine-shift steps, truncated to the phase width.
  function automatic logic [PHASE_W-1:0] code_to_steps(input logic [CODE_W-1:0] code,
                                                       input int unsigned        steps);
    return PHASE_W'(32'(code) * steps);
  endfunction

endpackage

// File: rtl/cmp_phase_shifter_req_edge_latch.sv
// Rising-edge detector with a sticky pending flag. The flag is set by a
// rising edge of req and cleared only when the consumer pulses clr.
module req_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic pend
);

  logic req_d;

  // Delay the request one cycle, flag its rising edge; a new edge beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_d <= req;
      if (req && !req_d) begin
        pend <= 1'b1;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmp_phase_shifter.sv
// Steps the comparator-clock MMCM fine phase one PSEN pulse at a time
// towards CMP_CLK_PHASE * STEPS_PER_CODE, and handles MMCM reset requests
// that return the accumulated phase to zero.
module cmp_phase_shifter
  import cmp_phase_shifter_pkg::*;
#(
  parameter int unsigned STEPS_PER_CODE = 35,
  parameter int unsigned RST_CYCLES     = 8,
  parameter int unsigned PSDONE_TMO     = 63
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMP_PHS_CHANGE,
  input  logic [CODE_W-1:0]  CMP_CLK_PHASE,
  input  logic               CMP_PHS_JTAG_RST,
  input  logic               MMCM_LOCK,
  input  logic               PSDONE,
  output logic               PSEN,
  output logic               PSINCDEC,
  output logic               CMP_PHS_RST,
  output logic [PHASE_W-1:0] CMP_PHASE,
  output logic               BUSY,
  output logic [2:0]         STATE,
  output logic               PS_ERR
);

  localparam int unsigned CNT_MAX = (PSDONE_TMO > RST_CYCLES) ? PSDONE_TMO : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PSDONE_TMO - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  phs_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [PHASE_W-1:0] target;
  logic [PHASE_W-1:0] load_target;
  logic [PHASE_W-1:0] phase_next;
  logic               chg_pend;
  logic               jtag_pend;
  logic               chg_clr;
  logic               jtag_clr;

  req_edge_latch u_chg_req (
    .clk  (CLK),
    .rst  (RST),
    .req  (CMP_PHS_CHANGE),
    .clr  (chg_clr),
    .pend (chg_pend)
  );

  req_edge_latch u_jtag_req (
    .clk  (CLK),
    .rst  (RST),
    .req  (CMP_PHS_JTAG_RST),
    .clr  (jtag_clr),
    .pend (jtag_pend)
  );

  // Pending requests are consumed only when IDLE dispatches them; JTAG reset has priority.
  always_comb begin
    jtag_clr = (state == ST_IDLE) && jtag_pend;
    chg_clr  = (state == ST_IDLE) && !jtag_pend && chg_pend;
  end

  // Target for the current code, and the phase after one acknowledged step (saturating).
  always_comb begin
    load_target = code_to_steps(CMP_CLK_PHASE, STEPS_PER_CODE);
    phase_next  = CMP_PHASE;
    if (PSINCDEC) begin
      if (CMP_PHASE != '1) phase_next = CMP_PHASE + PHASE_W'(1);
    end else begin
      if (CMP_PHASE != '0) phase_next = CMP_PHASE - PHASE_W'(1);
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    STATE = state;
    BUSY  = (state != ST_IDLE);
  end

  // Control FSM. PSEN and CMP_PHS_RST are set on entry to STEP/MRST so they
  // coincide exactly with those states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      target      <= '0;
      PSEN        <= 1'b0;
      PSINCDEC    <= 1'b0;
      CMP_PHS_RST <= 1'b0;
      CMP_PHASE   <= '0;
      PS_ERR      <= 1'b0;
    end else begin
      PSEN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (jtag_pend) begin
            state       <= ST_MRST;
            CMP_PHS_RST <= 1'b1;
            cnt         <= '0;
          end else if (chg_pend) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          target <= load_target;
          if (load_target == CMP_PHASE) begin
            state <= ST_DONE;
          end else begin
            state    <= ST_STEP;
            PSEN     <= 1'b1;
            PSINCDEC <= (load_target > CMP_PHASE);
          end
        end
        ST_STEP: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
        ST_WAIT: begin
          if (PSDONE) begin
            CMP_PHASE <= phase_next;
            if (phase_next == target) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_STEP;
              PSEN     <= 1'b1;
              PSINCDEC <= (target > phase_next);
            end
          end else if (cnt == TMO_LAST) begin
            PS_ERR <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_MRST: begin
          if (cnt == RST_LAST) begin
            CMP_PHS_RST <= 1'b0;
            state       <= ST_LOCKW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LOCKW: begin
          if (MMCM_LOCK) begin
            CMP_PHASE <= '0;
            PS_ERR    <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
